scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter NCH, default 4, number of input channels (2..16).
REQ-002 Parameter W, default 1, bit width of each channel.
REQ-003 Parameter DW, default 8, width of dwell count.
REQ-004 Derived constant SELW = clog2(NCH), channel index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 din  input  NCH*W  packed channel data; channel k at bits [k*W +: W].
REQ-008 sel  input  SELW  channel select, used in direct mode.
REQ-009 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-010 en  input  1  block enable.
REQ-011 dwell  input  DW  scan-mode cycles per channel minus one.
REQ-012 op  output  W  registered selected data.
REQ-013 op_ch  output  SELW  channel index that produced op.
REQ-014 op_valid  output  1  op/op_ch valid this cycle.
REQ-015 wrap  output  1  one-cycle pulse when scan returns from NCH-1 to 0.
REQ-016 sel_err  output  1  one-cycle pulse when direct sel >= NCH.

Function
REQ-017 FSM states IDLE, DIRECT, SCAN; next state evaluated every cycle from en and mode.
REQ-018 en=0 -> IDLE next cycle; op and op_ch hold their last values; op_valid=0; wrap=0; sel_err=0.
REQ-019 en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-020 DIRECT: op <= din[sel], op_ch <= sel, op_valid <= 1; latency exactly one cycle from sel/din to op.
REQ-021 DIRECT with sel >= NCH (NCH not a power of two): op <= 0, op_ch <= sel, op_valid <= 0, sel_err <= 1 for that cycle.
REQ-022 SCAN entry (from IDLE or DIRECT): scan channel index <= 0, dwell counter <= 0; first output cycle shows channel 0.
REQ-023 SCAN: each cycle op <= din[ch], op_ch <= ch, op_valid <= 1.
REQ-024 SCAN: dwell counter increments each cycle; when counter == dwell, counter <= 0 and ch advances by 1.
REQ-025 dwell=0 -> channel advances every cycle.
REQ-026 Advance from NCH-1 -> ch <= 0 and wrap pulses high for the cycle op_ch first shows 0 after the wrap; no wrap pulse on SCAN entry.
REQ-027 dwell sampled every cycle; if dwell is lowered below current counter, advance occurs when counter reaches all-ones and wraps to 0 (no stall, no skip).
REQ-028 mode toggle mid-scan takes effect next cycle; returning to SCAN always restarts at channel 0.
REQ-029 en deassert mid-scan freezes nothing internal except outputs; re-enable restarts scan at channel 0.
REQ-030 din changes during dwell are reflected in op with one-cycle latency (data not latched per channel).

Reset
REQ-031 rst_n=0 at rising clk: state <= IDLE, op <= 0, op_ch <= 0, op_valid <= 0, wrap <= 0, sel_err <= 0, ch <= 0, dwell counter <= 0.
REQ-032 Reset overrides en, mode and all data inputs in the same cycle; first active output cycle is the cycle after rst_n rises with en=1.

Structure
REQ-033 Package scan_mux_pkg holds FSM state typedef (IDLE, DIRECT, SCAN) and mode constants MODE_DIRECT=0, MODE_SCAN=1.
REQ-034 Dwell counter plus channel index advance implemented in sub-module scan_ctr (parameters NCH, DW; outputs ch, wrap_next).
REQ-035 No latches; single clocked process for all registered outputs.

Verification
REQ-036 NCH=4,W=1: DIRECT, din=4'b1010, sweep sel 0..3 -> op = 0,1,0,1 one cycle after each sel, op_valid=1.
REQ-037 NCH=4, mode=1, dwell=2, din=4'b0110 -> op_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only on the 13th output cycle.
REQ-038 NCH=3: DIRECT sel=3 -> next cycle op=0, op_valid=0, sel_err=1 for one cycle; sel=2 next -> sel_err=0, op_valid=1.
REQ-039 SCAN dwell=0 at op_ch=2, drive mode=0 sel=1 one cycle then mode=1 -> op_ch 1 then restarts 0,1,2.
REQ-040 Mid-scan (op_ch=2) drive rst_n=0 one cycle -> all outputs 0 next cycle; en=1 mode=1 after release -> op_ch starts at 0.
REQ-041 en=0 for 5 cycles in SCAN -> op/op_ch hold, op_valid=0; en=1 -> op_ch=0, op_valid=1, no wrap pulse.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared types for scan_mux: FSM state encoding and mode select constants.
package scan_mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DIRECT = 2'd1;
  localparam state_t ST_SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_if.sv
// Channel-mux bus: packed channel data and controls in, registered selection out.
interface scan_mux_if #(
  parameter int NCH = 4,
  parameter int W   = 1,
  parameter int DW  = 8
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*W-1:0] din;
  logic [SELW-1:0]  sel;
  logic             mode;
  logic             en;
  logic [DW-1:0]    dwell;
  logic [W-1:0]     op;
  logic [SELW-1:0]  op_ch;
  logic             op_valid;
  logic             wrap;
  logic             sel_err;

  modport master (output din, sel, mode, en, dwell,
                  input  op, op_ch, op_valid, wrap, sel_err);
  modport slave  (input  din, sel, mode, en, dwell,
                  output op, op_ch, op_valid, wrap, sel_err);
endinterface

// File: rtl/scan_mux_ctr.sv
// Scan dwell counter and channel index; ch is the channel for the current cycle.
// restart forces channel 0 / count 0 so scan entry never reports a wrap.
module scan_ctr #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    restart,
  input  logic [DW-1:0]           dwell,
  output logic [$clog2(NCH)-1:0]  ch,
  output logic                    wrap_next
);
  localparam int SELW = $clog2(NCH);
  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [SELW-1:0] ch_q;
  logic [DW-1:0]   cnt_q;
  logic [DW-1:0]   cnt_cur;
  logic            done;

  // An all-ones counter also advances, so lowering dwell below the count never stalls.
  always_comb begin
    ch        = restart ? '0 : ch_q;
    cnt_cur   = restart ? '0 : cnt_q;
    done      = (cnt_cur == dwell) || (cnt_cur == '1);
    wrap_next = !restart && (ch_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q  <= '0;
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= done ? '0 : cnt_cur + 1'b1;
      if (done)
        ch_q <= (ch == LAST) ? '0 : ch + 1'b1;
      else
        ch_q <= ch;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with direct select or auto-scan; one cycle input-to-output latency.
// No backpressure: a new selection is registered every enabled cycle.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 1,
  parameter int DW  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  scan_mux_if.slave bus
);
  localparam int SELW = $clog2(NCH);
  localparam logic [SELW:0] NCH_X = (SELW + 1)'(NCH);

  state_t          state;
  logic [W-1:0]    chan [1 << SELW];
  logic [SELW-1:0] ch;
  logic            wrap_next;
  logic            run;
  logic            restart;
  logic            sel_ok;

  // Unused index slots read as zero so an out-of-range sel never indexes past the array.
  for (genvar k = 0; k < (1 << SELW); k++) begin : g_chan
    if (k < NCH) begin : g_real
      assign chan[k] = bus.din[k*W +: W];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  assign run     = bus.en && (bus.mode == MODE_SCAN);
  assign restart = (state != ST_SCAN);
  assign sel_ok  = ({1'b0, bus.sel} < NCH_X);

  scan_ctr #(.NCH(NCH), .DW(DW)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .restart   (restart),
    .dwell     (bus.dwell),
    .ch        (ch),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bus.op       <= '0;
      bus.op_ch    <= '0;
      bus.op_valid <= 1'b0;
      bus.wrap     <= 1'b0;
      bus.sel_err  <= 1'b0;
    end else begin
      bus.wrap    <= 1'b0;
      bus.sel_err <= 1'b0;
      if (!bus.en) begin
        state        <= ST_IDLE;
        bus.op_valid <= 1'b0;
      end else if (bus.mode == MODE_DIRECT) begin
        state     <= ST_DIRECT;
        bus.op_ch <= bus.sel;
        if (sel_ok) begin
          bus.op       <= chan[bus.sel];
          bus.op_valid <= 1'b1;
        end else begin
          bus.op       <= '0;
          bus.op_valid <= 1'b0;
          bus.sel_err  <= 1'b1;
        end
      end else begin
        state        <= ST_SCAN;
        bus.op       <= chan[ch];
        bus.op_ch    <= ch;
        bus.op_valid <= 1'b1;
        bus.wrap     <= wrap_next;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux with a 4-channel and a 3-channel instance.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scan_mux_if #(.NCH(4), .W(1), .DW(8)) b4 ();
  scan_mux_if #(.NCH(3), .W(1), .DW(8)) b3 ();

  scan_mux #(.NCH(4), .W(1), .DW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  scan_mux #(.NCH(3), .W(1), .DW(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct packed {
    logic       op;
    logic [1:0] op_ch;
    logic       op_valid;
    logic       wrap;
    logic       sel_err;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  int   step   = 0;

  function automatic exp_t mk(logic o, logic [1:0] c, logic v, logic w, logic e);
    exp_t x;
    x.op = o; x.op_ch = c; x.op_valid = v; x.wrap = w; x.sel_err = e;
    return x;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL step%0d %s: observed %0d expected %0d", step, tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare every queued expectation against the outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    step++;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("dut4.op",       8'(b4.op),       8'(e.op));
      chk("dut4.op_ch",    8'(b4.op_ch),    8'(e.op_ch));
      chk("dut4.op_valid", 8'(b4.op_valid), 8'(e.op_valid));
      chk("dut4.wrap",     8'(b4.wrap),     8'(e.wrap));
      chk("dut4.sel_err",  8'(b4.sel_err),  8'(e.sel_err));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("dut3.op",       8'(b3.op),       8'(e.op));
      chk("dut3.op_ch",    8'(b3.op_ch),    8'(e.op_ch));
      chk("dut3.op_valid", 8'(b3.op_valid), 8'(e.op_valid));
      chk("dut3.wrap",     8'(b3.wrap),     8'(e.wrap));
      chk("dut3.sel_err",  8'(b3.sel_err),  8'(e.sel_err));
    end
  endtask

  initial begin
    logic [3:0] d;
    logic [2:0] d3;
    logic [3:0] r;
    logic [1:0] c;

    rst_n = 1'b0;
    b4.din = '0; b4.sel = '0; b4.mode = 1'b0; b4.en = 1'b0; b4.dwell = '0;
    b3.din = '0; b3.sel = '0; b3.mode = 1'b0; b3.en = 1'b0; b3.dwell = '0;

    // Reset state, with en held high on dut4 to show reset wins.
    b4.en = 1'b1; b4.mode = 1'b1; b4.din = 4'hF;
    for (int i = 0; i < 2; i++) begin
      q4.push_back(mk(0, 0, 0, 0, 0));
      q3.push_back(mk(0, 0, 0, 0, 0));
      tick();
    end
    b4.en = 1'b0; b4.mode = 1'b0; b4.din = '0;
    rst_n = 1'b1;

    // 3-channel instance: out-of-range select, recovery, short scan with wrap.
    d3 = 3'b101;
    b3.din = d3; b3.en = 1'b1; b3.mode = 1'b0; b3.sel = 2'd3;
    q3.push_back(mk(0, 3, 0, 0, 1)); tick();
    b3.sel = 2'd2;
    q3.push_back(mk(d3[2], 2, 1, 0, 0)); tick();
    b3.sel = 2'd1;
    q3.push_back(mk(d3[1], 1, 1, 0, 0)); tick();
    b3.mode = 1'b1; b3.dwell = 8'd0;
    for (int i = 0; i < 4; i++) begin
      c = 2'(i % 3);
      q3.push_back(mk(d3[c], c, 1, (i == 3), 0)); tick();
    end
    b3.en = 1'b0;
    q3.push_back(mk(d3[0], 0, 0, 0, 0)); tick();

    // Direct select sweep.
    d = 4'b1010;
    b4.din = d; b4.en = 1'b1; b4.mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      b4.sel = 2'(s);
      q4.push_back(mk(d[s], 2'(s), 1, 0, 0)); tick();
    end

    // Scan with dwell=2 through one full wrap.
    d = 4'b0110;
    b4.din = d; b4.mode = 1'b1; b4.dwell = 8'd2;
    for (int i = 0; i < 13; i++) begin
      c = 2'((i / 3) % 4);
      q4.push_back(mk(d[c], c, 1, (i == 12), 0)); tick();
    end

    b4.en = 1'b0;
    q4.push_back(mk(d[0], 0, 0, 0, 0)); tick();

    // dwell=0 scan, one direct cycle, then scan restarts at channel 0.
    b4.en = 1'b1; b4.mode = 1'b1; b4.dwell = 8'd0;
    for (int i = 0; i < 3; i++) begin
      q4.push_back(mk(d[i], 2'(i), 1, 0, 0)); tick();
    end
    b4.mode = 1'b0; b4.sel = 2'd1;
    q4.push_back(mk(d[1], 1, 1, 0, 0)); tick();
    b4.mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q4.push_back(mk(d[i], 2'(i), 1, 0, 0)); tick();
    end

    // Disable for 5 cycles: outputs hold, valid low; re-enable restarts without a wrap.
    b4.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q4.push_back(mk(d[2], 2, 0, 0, 0)); tick();
    end
    b4.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      c = 2'(i % 4);
      q4.push_back(mk(d[c], c, 1, (i == 4), 0)); tick();
    end

    // Reset mid-scan (op_ch=2 showing), then scan resumes from channel 0.
    rst_n = 1'b0;
    q4.push_back(mk(0, 0, 0, 0, 0));
    q3.push_back(mk(0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1;

    // dwell lowered below the running count: counter runs to all-ones before advancing.
    b4.dwell = 8'd3;
    for (int i = 0; i < 260; i++) begin
      if (i == 3) b4.dwell = 8'd1;
      r = 4'($urandom);
      b4.din = r;
      c = (i < 256) ? 2'd0 : ((i < 258) ? 2'd1 : 2'd2);
      q4.push_back(mk(r[c], c, 1, 0, 0)); tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
